// File: rtl/piso_sipo_pkg.sv
// ----------------------------------------------------------------------------
// piso_sipo_pkg : shared state encodings and defaults for the serial link.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package piso_sipo_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_sync.sv
// ----------------------------------------------------------------------------
// fifo_sync : single-clock show-ahead FIFO with wrap-bit pointers.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_sync
  import piso_sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     wr_en_i,
  output logic                     full_o,
  output logic [WIDTH-1:0]         rdata_o,
  input  logic                     rd_en_i,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // Pointer difference modulo 2*DEPTH is exactly the occupancy.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_wr    = wr_en_i && !full_o;
    do_rd    = rd_en_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/sipo_rx.sv
// ----------------------------------------------------------------------------
// sipo_rx : serial-in/parallel-out receiver, LSB first, with word FIFO.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sipo_rx
  import piso_sipo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     frame_err_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = $clog2(TIMEOUT);

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             frame_err_q, frame_err_d;

  logic             full, empty, push, pop, beat, last_bit;

  assign last_bit    = (bit_cnt_q == CW'(WIDTH-1));
  assign ready_o     = !(last_bit && full);
  assign beat        = valid_i && ready_o;
  assign pop         = valid_o && ready_i;
  assign valid_o     = !empty;
  assign frame_err_o = frame_err_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    idle_cnt_d  = idle_cnt_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    if (beat) begin
      idle_cnt_d = '0;
      if (last_bit) begin
        push      = 1'b1;
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end else begin
        for (int i = 0; i < WIDTH-1; i++) begin
          if (bit_cnt_q == CW'(i)) shift_d[i] = data_i;
        end
        bit_cnt_d = bit_cnt_q + CW'(1);
        state_d   = S_SHIFT;
      end
    // A full-FIFO stall (ready_o=0) freezes the idle counter.
    end else if (state_q == S_SHIFT && ready_o && !valid_i) begin
      if (idle_cnt_q == IW'(TIMEOUT-1)) begin
        idle_cnt_d  = '0;
        bit_cnt_d   = '0;
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idle_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idle_cnt_q  <= idle_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wdata_i ({data_i, shift_q}),
    .wr_en_i (push),
    .full_o  (full),
    .rdata_o (data_o),
    .rd_en_i (pop),
    .empty_o (empty),
    .level_o (level_o)
  );

endmodule

`default_nettype wire
